lza_norm_seq: RTL and testbench
===============================

LZA_NORM_SEQ -- requirements
Module: lza_norm_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 25, mantissa/LZA datapath width.
REQ-002 SHALL have parameter: EW, 8, exponent width.
REQ-003 SHALL have parameter: CW, $clog2(WIDTH)+1, LZA count width (6 at default).
REQ-004 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports: in_valid input 1 and in_ready output 1, request handshake.
REQ-007 SHALL have ports: in_op_a input WIDTH and in_op_b input WIDTH, aligned mantissas, unsigned; in_exp input EW, common pre-normalize exponent.
REQ-008 SHALL have ports: lza_op_a output WIDTH and lza_op_b output WIDTH, drive the external combinational LZA (larger operand on lza_op_a).
REQ-009 SHALL have ports: lza_count input CW, predicted leading-zero count; lza_err input 1, LZA correction-tree flag.
REQ-010 SHALL have ports: out_valid output 1 and out_ready input 1, result handshake.
REQ-011 SHALL have ports: out_mant output WIDTH; out_exp output EW; out_zero, out_swap, out_uflow, out_corr, out_err_mismatch, busy, each output 1.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, SHIFT, CORR, DONE.
REQ-013 SHALL assert in_ready only in IDLE; accept on in_valid&&in_ready, then go to CALC.
REQ-014 On accept, SHALL register larger operand as A and smaller as B, with out_swap=1 iff in_op_b>in_op_a; SHALL also register D=A-B (WIDTH bits, never negative) and in_exp.
REQ-015 SHALL drive lza_op_a/lza_op_b from registered A/B, held constant from CALC through DONE, and drive 0 in IDLE.
REQ-016 In CALC, SHALL sample lza_count and lza_err.
REQ-017 In CALC, if D==0, SHALL set out_zero=1, out_mant=0, out_exp=0 and go to DONE; otherwise SHALL go to SHIFT.
REQ-018 Shift amount SHALL be min(lza_count, WIDTH-1, in_exp).
REQ-019 out_uflow SHALL be 1 iff in_exp < min(lza_count, WIDTH-1).
REQ-020 In SHIFT, SHALL left-shift D by the shift amount and set exp = in_exp - shift amount, with no wrap below 0.
REQ-021 In CORR, if shifted MSB==0 and exp>0 and not out_uflow, SHALL shift left one more, decrement exp, and set out_corr=1; otherwise out_corr=0.
REQ-022 In CORR, SHALL set out_err_mismatch = lza_err XOR out_corr, sampled at CALC; this flag is diagnostic only.
REQ-023 SHALL assert out_valid only in DONE; results SHALL be held stable while out_valid&&!out_ready.
REQ-024 On out_valid&&out_ready, SHALL return to IDLE, making in_ready=1 on the next cycle; back-to-back throughput is one result per 5 cycles.
REQ-025 Latency, accept edge to out_valid high: 4 cycles for the nonzero path, 2 cycles for the zero path.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 in_valid asserted outside IDLE SHALL be ignored, with no effect on state or data.

Reset
REQ-028 While rst_n=0, SHALL force state=IDLE; in_ready=1; out_valid=0; busy=0; out_mant, out_exp, lza_op_a, lza_op_b = 0; all flags = 0.
REQ-029 Reset asserted in any state SHALL abort the operation with no out_valid pulse; first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL cover: a=0x1000000, b=0x0800000, exp=100, exact LZA model -> out_mant=0x1000000, out_exp=99, out_corr=0, out_valid 4 cycles after accept.
REQ-031 SHALL cover: a=b=0x0123456 -> out_zero=1, out_mant=0, out_exp=0, out_valid 2 cycles after accept.
REQ-032 SHALL cover: a=0x0000010, b=0x0000020, exp=10 -> out_swap=1, D=0x10, out_uflow=1, out_mant=0x4000, out_exp=0.
REQ-033 SHALL cover: LZA model returning true count minus 1 with lza_err=1, D=0x0000F00, exp=50 -> out_corr=1, out_err_mismatch=0, out_mant=0x1E00000, out_exp=37.
REQ-034 SHALL cover: out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; after handshake, in_ready=1 next cycle.
REQ-035 SHALL cover: rst_n pulsed low during SHIFT -> out_valid never asserts, all outputs at reset values, and the next request completes correctly.

Source files
------------

// File: rtl/lza_norm_seq_if.sv
// Request/LZA/result signal bundle for the sequential LZA-driven normalizer.
// slave is the normalizer's view; master is the requester/LZA/consumer side.
interface lza_norm_seq_if #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned EW    = 8,
    parameter int unsigned CW    = $clog2(WIDTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_op_a;
    logic [WIDTH-1:0] in_op_b;
    logic [EW-1:0]    in_exp;
    logic [WIDTH-1:0] lza_op_a;
    logic [WIDTH-1:0] lza_op_b;
    logic [CW-1:0]    lza_count;
    logic             lza_err;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mant;
    logic [EW-1:0]    out_exp;
    logic             out_zero;
    logic             out_swap;
    logic             out_uflow;
    logic             out_corr;
    logic             out_err_mismatch;
    logic             busy;

    modport slave (
        input  in_valid, in_op_a, in_op_b, in_exp, lza_count, lza_err, out_ready,
        output in_ready, lza_op_a, lza_op_b, out_valid, out_mant, out_exp,
               out_zero, out_swap, out_uflow, out_corr, out_err_mismatch, busy
    );

    modport master (
        output in_valid, in_op_a, in_op_b, in_exp, lza_count, lza_err, out_ready,
        input  in_ready, lza_op_a, lza_op_b, out_valid, out_mant, out_exp,
               out_zero, out_swap, out_uflow, out_corr, out_err_mismatch, busy
    );
endinterface

// File: rtl/lza_norm_seq.sv
// Sequential normalizer: orders operands, takes |A-B|, shifts by an external
// LZA prediction (clamped by exponent) and fixes a one-bit underestimate.
module lza_norm_seq #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned EW    = 8,
    parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
    input logic           clk,
    input logic           rst_n,
    lza_norm_seq_if.slave bus
);
    localparam int unsigned SW = ((CW > EW) ? CW : EW) + 1;

    typedef enum logic [2:0] {IDLE, CALC, SHIFT, CORR, DONE} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d, mant_q, mant_d;
    logic [EW-1:0]    exp_in_q, exp_in_d, exp_q, exp_d;
    logic [SW-1:0]    sh_q, sh_d;
    logic             swap_q, swap_d, zero_q, zero_d, uflow_q, uflow_d;
    logic             corr_q, corr_d, mism_q, mism_d, err_q, err_d;

    logic [SW-1:0]    lim_c, sh_c;
    logic             uflow_c;

    // Shift amount = min(count, WIDTH-1, exp); underflow when exp is the binding limit
    always_comb begin : shift_amt
        lim_c   = (SW'(bus.lza_count) < SW'(WIDTH - 1)) ? SW'(bus.lza_count) : SW'(WIDTH - 1);
        uflow_c = SW'(exp_in_q) < lim_c;
        sh_c    = uflow_c ? SW'(exp_in_q) : lim_c;
    end

    always_comb begin : next_state
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        mant_d   = mant_q;
        exp_in_d = exp_in_q;
        exp_d    = exp_q;
        sh_d     = sh_q;
        swap_d   = swap_q;
        zero_d   = zero_q;
        uflow_d  = uflow_q;
        corr_d   = corr_q;
        mism_d   = mism_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_op_b > bus.in_op_a) begin
                        a_d    = bus.in_op_b;
                        b_d    = bus.in_op_a;
                        swap_d = 1'b1;
                    end else begin
                        a_d    = bus.in_op_a;
                        b_d    = bus.in_op_b;
                        swap_d = 1'b0;
                    end
                    d_d      = a_d - b_d;
                    exp_in_d = bus.in_exp;
                    mant_d   = '0;
                    exp_d    = '0;
                    sh_d     = '0;
                    zero_d   = 1'b0;
                    uflow_d  = 1'b0;
                    corr_d   = 1'b0;
                    mism_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                err_d = bus.lza_err;
                if (d_q == '0) begin
                    zero_d  = 1'b1;
                    mant_d  = '0;
                    exp_d   = '0;
                    state_d = DONE;
                end else begin
                    sh_d    = sh_c;
                    uflow_d = uflow_c;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                mant_d  = d_q << sh_q;
                exp_d   = exp_in_q - EW'(sh_q);
                state_d = CORR;
            end
            CORR: begin
                // LZA may underestimate by one; fix it unless exponent is exhausted
                if (!mant_q[WIDTH-1] && (exp_q != '0) && !uflow_q) begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EW'(1);
                    corr_d = 1'b1;
                end else begin
                    corr_d = 1'b0;
                end
                mism_d  = err_q ^ corr_d;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    a_d     = '0;
                    b_d     = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            mant_q      <= '0;
            exp_in_q    <= '0;
            exp_q       <= '0;
            sh_q        <= '0;
            swap_q      <= 1'b0;
            zero_q      <= 1'b0;
            uflow_q     <= 1'b0;
            corr_q      <= 1'b0;
            mism_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            a_q         <= a_d;
            b_q         <= b_d;
            d_q         <= d_d;
            mant_q      <= mant_d;
            exp_in_q    <= exp_in_d;
            exp_q       <= exp_d;
            sh_q        <= sh_d;
            swap_q      <= swap_d;
            zero_q      <= zero_d;
            uflow_q     <= uflow_d;
            corr_q      <= corr_d;
            mism_q      <= mism_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.busy             = busy_q;
    assign bus.lza_op_a         = a_q;
    assign bus.lza_op_b         = b_q;
    assign bus.out_mant         = mant_q;
    assign bus.out_exp          = exp_q;
    assign bus.out_zero         = zero_q;
    assign bus.out_swap         = swap_q;
    assign bus.out_uflow        = uflow_q;
    assign bus.out_corr         = corr_q;
    assign bus.out_err_mismatch = mism_q;
endmodule

// File: tb/tb_lza_norm_seq.sv
// Bench for lza_norm_seq: directed table, stall/reset sequences and random
// requests checked against an arithmetic reference model.
module tb_lza_norm_seq;
    localparam int unsigned W  = 25;
    localparam int unsigned EW = 8;
    localparam int unsigned CW = $clog2(W) + 1;

    typedef struct packed {
        logic [W-1:0]  mant;
        logic [EW-1:0] e;
        logic          zero, swap, uflow, corr, mism;
    } res_t;

    typedef struct {
        logic [W-1:0]  a, b;
        logic [EW-1:0] e;
        bit            delta, err;
        res_t          r;
        int            lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   lza_delta, lza_err_drv;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[10];

    lza_norm_seq_if #(.WIDTH(W), .EW(EW), .CW(CW)) bus ();
    lza_norm_seq #(.WIDTH(W), .EW(EW), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int lzc(input logic [W-1:0] x);
        int n = W;
        for (int i = 0; i < int'(W); i++) if (x[i]) n = W - 1 - i;
        return n;
    endfunction

    // External LZA stand-in: exact count, optionally one short
    always_comb begin : lza_drv
        int c;
        c = lzc(W'(bus.lza_op_a - bus.lza_op_b));
        if (lza_delta && c > 0) c = c - 1;
        bus.lza_count = CW'(c);
        bus.lza_err   = lza_err_drv;
    end

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [EW-1:0] e, input bit delta, input bit err);
        res_t   r;
        longint d, m;
        int     cnt, lim, sh, ee;
        r      = '0;
        r.swap = (b > a);
        d      = r.swap ? longint'(b) - longint'(a) : longint'(a) - longint'(b);
        if (d == 0) begin
            r.zero = 1'b1;
            return r;
        end
        cnt     = lzc(W'(d));
        if (delta && cnt > 0) cnt = cnt - 1;
        lim     = (cnt < int'(W) - 1) ? cnt : int'(W) - 1;
        r.uflow = int'(e) < lim;
        sh      = (lim < int'(e)) ? lim : int'(e);
        m       = d << sh;
        ee      = int'(e) - sh;
        if (((m >> (W - 1)) & 1) == 0 && ee > 0 && !r.uflow) begin
            m      = m << 1;
            ee     = ee - 1;
            r.corr = 1'b1;
        end
        r.mant = W'(m);
        r.e    = EW'(ee);
        r.mism = err ^ r.corr;
        return r;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input int e,
                                input bit delta, input bit err, input logic [W-1:0] mant,
                                input int ee, input bit z, input bit s, input bit u,
                                input bit c, input bit mm);
        vec_t v;
        v.a = a; v.b = b; v.e = EW'(e); v.delta = delta; v.err = err;
        v.r.mant = mant; v.r.e = EW'(ee);
        v.r.zero = z; v.r.swap = s; v.r.uflow = u; v.r.corr = c; v.r.mism = mm;
        v.lat = z ? 2 : 4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_mant"}, bus.out_mant, 0);
        chk({tag, "_exp"}, bus.out_exp, 0);
        chk({tag, "_lza_a"}, bus.lza_op_a, 0);
        chk({tag, "_lza_b"}, bus.lza_op_b, 0);
        chk({tag, "_flags"}, {bus.out_zero, bus.out_swap, bus.out_uflow,
                              bus.out_corr, bus.out_err_mismatch}, 0);
    endtask

    task automatic drive_req(input vec_t v);
        bus.in_valid = 1'b1;
        bus.in_op_a  = v.a;
        bus.in_op_b  = v.b;
        bus.in_exp   = v.e;
        lza_delta    = v.delta;
        lza_err_drv  = v.err;
    endtask

    task automatic run_vec(input vec_t v, input bit stall, input bit at_neg);
        int lat;
        if (!at_neg) @(negedge clk);
        drive_req(v);
        bus.out_ready = !stall;
        chk("in_ready_idle", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("busy_after_accept", bus.busy, 1);
        chk("lza_op_a_larger", bus.lza_op_a, (v.b > v.a) ? v.b : v.a);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, v.lat);
        chk("out_mant", bus.out_mant, v.r.mant);
        chk("out_exp", bus.out_exp, v.r.e);
        chk("out_zero", bus.out_zero, v.r.zero);
        chk("out_swap", bus.out_swap, v.r.swap);
        chk("out_uflow", bus.out_uflow, v.r.uflow);
        chk("out_corr", bus.out_corr, v.r.corr);
        chk("out_err_mismatch", bus.out_err_mismatch, v.r.mism);
        chk("in_ready_done", bus.in_ready, 0);
        if (stall) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_op_a  = W'($urandom);
                bus.in_op_b  = W'($urandom);
                bus.in_exp   = EW'($urandom);
                @(posedge clk); #1;
                chk("stall_out_valid", bus.out_valid, 1);
                chk("stall_mant", bus.out_mant, v.r.mant);
                chk("stall_exp", bus.out_exp, v.r.e);
                chk("stall_flags", {bus.out_zero, bus.out_swap, bus.out_uflow, bus.out_corr,
                                    bus.out_err_mismatch},
                    {v.r.zero, v.r.swap, v.r.uflow, v.r.corr, v.r.mism});
                chk("stall_in_ready", bus.in_ready, 0);
            end
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("in_ready_after_hs", bus.in_ready, 1);
        chk("out_valid_after_hs", bus.out_valid, 0);
        chk("lza_op_a_idle", bus.lza_op_a, 0);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        vec_t v;
        bus.in_valid = 1'b0; bus.in_op_a = '0; bus.in_op_b = '0; bus.in_exp = '0;
        bus.out_ready = 1'b1; lza_delta = 1'b0; lza_err_drv = 1'b0;

        //            a          b          exp  dl er  mant       e    z  s  u  c  m
        tbl[0] = mk(25'h1000000, 25'h0800000, 100, 0, 0, 25'h1000000, 99, 0, 0, 0, 0, 0);
        tbl[1] = mk(25'h0123456, 25'h0123456, 77,  0, 0, 25'h0,       0,  1, 0, 0, 0, 0);
        tbl[2] = mk(25'h0000010, 25'h0000020, 10,  0, 0, 25'h0004000, 0,  0, 1, 1, 0, 0);
        tbl[3] = mk(25'h0000F00, 25'h0,       50,  1, 1, 25'h1E00000, 37, 0, 0, 0, 1, 0);
        tbl[4] = mk(25'h1FFFFFF, 25'h0,       5,   0, 0, 25'h1FFFFFF, 5,  0, 0, 0, 0, 0);
        tbl[5] = mk(25'h0000001, 25'h0,       200, 0, 0, 25'h1000000, 176,0, 0, 0, 0, 0);
        tbl[6] = mk(25'h0000003, 25'h1,       0,   0, 0, 25'h0000002, 0,  0, 0, 1, 0, 0);
        tbl[7] = mk(25'h0000100, 25'h0,       50,  0, 1, 25'h1000000, 34, 0, 0, 0, 0, 1);
        tbl[8] = mk(25'h0000F00, 25'h0,       12,  1, 1, 25'h0F00000, 0,  0, 0, 0, 0, 1);
        tbl[9] = mk(25'h0,       25'h0000F00, 13,  1, 0, 25'h1E00000, 0,  0, 1, 0, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], 1'b0, 1'b0);

        // Result held under backpressure, with in_valid ignored meanwhile
        run_vec(tbl[0], 1'b1, 1'b0);
        run_vec(tbl[3], 1'b0, 1'b0);

        // Reset abort in SHIFT, then accept on the first edge after release
        @(negedge clk);
        drive_req(tbl[9]);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort_out_valid", bus.out_valid, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(tbl[3], 1'b0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a, b;
            int sel;
            sel = $urandom_range(0, 3);
            a   = W'($urandom);
            case (sel)
                0: b = W'($urandom);
                1: begin a = a >> $urandom_range(0, 24); b = W'($urandom) >> $urandom_range(4, 24); end
                2: b = a;
                default: b = a ^ (W'($urandom) >> $urandom_range(0, 24));
            endcase
            v.a = a; v.b = b; v.e = EW'($urandom);
            v.delta = bit'($urandom_range(0, 1));
            v.err   = bit'($urandom_range(0, 1));
            v.r   = model(v.a, v.b, v.e, v.delta, v.err);
            v.lat = v.r.zero ? 2 : 4;
            run_vec(v, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
